// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake step controller: direction codes, FSM states,
// pixel coordinates and the wrap-around move arithmetic.
package snake_pkg;

    typedef logic [2:0] coord_t;
    typedef logic [5:0] pix_idx_t;

    typedef enum logic [2:0] {
        DirHold  = 3'b000,
        DirRight = 3'b001,
        DirDown  = 3'b011,
        DirUp    = 3'b100,
        DirLeft  = 3'b110
    } dir_t;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StScan,
        StCommit,
        StDraw,
        StClear,
        StOver
    } state_t;

    localparam pix_idx_t InitHead = 6'd10;

    // Unlisted codes collapse to hold.
    function automatic dir_t decode_dir(input logic [2:0] raw);
        case (raw)
            3'b100:  return DirUp;
            3'b001:  return DirRight;
            3'b110:  return DirLeft;
            3'b011:  return DirDown;
            default: return DirHold;
        endcase
    endfunction

    function automatic pix_idx_t next_pos(input pix_idx_t p, input dir_t d);
        coord_t c;
        coord_t r;
        c = p[5:3];
        r = p[2:0];
        case (d)
            DirUp:    r = r + 3'd1;
            DirDown:  r = r - 3'd1;
            DirRight: c = c + 3'd1;
            DirLeft:  c = c - 3'd1;
            default:  ;
        endcase
        return {c, r};
    endfunction

    function automatic logic is_reverse(input dir_t cur, input dir_t req);
        return ((cur == DirUp)    && (req == DirDown))  ||
               ((cur == DirDown)  && (req == DirUp))    ||
               ((cur == DirLeft)  && (req == DirRight)) ||
               ((cur == DirRight) && (req == DirLeft));
    endfunction

    // Initial body runs down column 1 from the head at row 2.
    function automatic pix_idx_t init_seg(input int unsigned k);
        return {3'd1, 3'(2 - k)};
    endfunction

endpackage

// File: rtl/snake_body_ring.sv
// Circular body store: entry at hd_ptr is the head, offsets grow toward the tail.
// A push moves the head pointer back one slot, so no entry ever shifts.
module snake_body_ring
    import snake_pkg::*;
#(
    parameter int unsigned MaxLen  = 64,
    parameter int unsigned InitLen = 3,
    localparam int unsigned PtrW   = $clog2(MaxLen)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            init_i,
    input  logic            push_i,
    input  pix_idx_t        push_data_i,
    input  logic [PtrW-1:0] rd_off_i,
    output pix_idx_t        rd_data_o,
    input  logic [PtrW-1:0] tail_off_i,
    output pix_idx_t        tail_data_o
);

    localparam logic [PtrW-1:0] PtrOne = 1;

    pix_idx_t        ring_q [MaxLen];
    pix_idx_t        ring_d [MaxLen];
    logic [PtrW-1:0] hd_ptr_q, hd_ptr_d;
    logic [PtrW-1:0] rd_idx, tail_idx;

    function automatic pix_idx_t init_val(input int unsigned k);
        return (k < InitLen) ? init_seg(k) : '0;
    endfunction

    always_comb begin
        ring_d   = ring_q;
        hd_ptr_d = hd_ptr_q;
        if (init_i) begin
            hd_ptr_d = '0;
            for (int unsigned k = 0; k < MaxLen; k++) begin
                ring_d[k] = init_val(k);
            end
        end else if (push_i) begin
            hd_ptr_d         = hd_ptr_q - PtrOne;
            ring_d[hd_ptr_d] = push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hd_ptr_q <= '0;
            for (int unsigned k = 0; k < MaxLen; k++) begin
                ring_q[k] <= init_val(k);
            end
        end else begin
            hd_ptr_q <= hd_ptr_d;
            ring_q   <= ring_d;
        end
    end

    assign rd_idx      = hd_ptr_q + rd_off_i;
    assign tail_idx    = hd_ptr_q + tail_off_i;
    assign rd_data_o   = ring_q[rd_idx];
    assign tail_data_o = ring_q[tail_idx];

endmodule

// File: rtl/snake_step_ctrl.sv
// Per-tick snake move sequencer: scans the body for collisions, commits the new head
// into the ring and issues single-pixel framebuffer set/clear writes.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [2:0] dir,
    input  logic       pause,
    input  logic       restart,
    input  logic [2:0] apple_c,
    input  logic [2:0] apple_r,
    output logic       fb_we,
    output logic [5:0] fb_addr,
    output logic       fb_val,
    output logic       apple_eaten,
    output logic [6:0] size,
    output logic [2:0] head_c,
    output logic [2:0] head_r,
    output logic       game_over,
    output logic       busy,
    output logic       tick_overrun
);

    localparam int unsigned PtrW     = $clog2(MAX_LEN);
    localparam logic [6:0]  InitSize = 7'(INIT_LEN);
    localparam logic [6:0]  MaxSize  = 7'(MAX_LEN);
    localparam logic [5:0]  InitLast = 6'(INIT_LEN - 1);

    state_t     state_q, state_d;
    dir_t       cur_dir_q, cur_dir_d;
    logic [5:0] cnt_q, cnt_d;
    logic       wipe_q, wipe_d;
    pix_idx_t   nxt_q, nxt_d;
    logic       grow_q, grow_d;
    logic       drop_tail_q, drop_tail_d;
    logic [6:0] scan_q, scan_d;
    pix_idx_t   tail_q, tail_d;
    logic [6:0] size_q, size_d;
    pix_idx_t   head_q, head_d;
    logic       game_over_q, game_over_d;
    logic       fb_we_q, fb_we_d;
    pix_idx_t   fb_addr_q, fb_addr_d;
    logic       fb_val_q, fb_val_d;
    logic       eaten_q, eaten_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;

    logic       ring_push;
    pix_idx_t   ring_rd, ring_tail;
    logic [6:0] last_idx;
    dir_t       dir_in, dir_sel;
    logic       hit;

    snake_body_ring #(
        .MaxLen  (MAX_LEN),
        .InitLen (INIT_LEN)
    ) u_ring (
        .clk_i       (CLK),
        .rst_ni      (reset_n),
        .init_i      (restart),
        .push_i      (ring_push),
        .push_data_i (nxt_q),
        .rd_off_i    (scan_q[PtrW-1:0]),
        .rd_data_o   (ring_rd),
        .tail_off_i  (last_idx[PtrW-1:0]),
        .tail_data_o (ring_tail)
    );

    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        cnt_d       = cnt_q;
        wipe_d      = wipe_q;
        nxt_d       = nxt_q;
        grow_d      = grow_q;
        drop_tail_d = drop_tail_q;
        scan_d      = scan_q;
        tail_d      = tail_q;
        size_d      = size_q;
        head_d      = head_q;
        game_over_d = game_over_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_val_d    = 1'b0;
        eaten_d     = 1'b0;
        overrun_d   = 1'b0;
        ring_push   = 1'b0;

        last_idx = size_q - 7'd1;
        dir_in   = decode_dir(dir);
        dir_sel  = ((dir_in != DirHold) && !is_reverse(cur_dir_q, dir_in)) ? dir_in : cur_dir_q;
        // The vacating tail cannot block the move unless the snake is growing.
        hit      = (grow_q || (scan_q != last_idx)) && (ring_rd == nxt_q);

        if (restart) begin
            state_d     = StInit;
            wipe_d      = 1'b1;
            cnt_d       = '0;
            size_d      = InitSize;
            head_d      = InitHead;
            cur_dir_d   = DirUp;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    fb_we_d = 1'b1;
                    if (wipe_q) begin
                        fb_addr_d = cnt_q;
                        cnt_d     = cnt_q + 6'd1;
                        if (cnt_q == 6'd63) begin
                            wipe_d = 1'b0;
                        end
                    end else begin
                        fb_addr_d = init_seg(32'(cnt_q));
                        fb_val_d  = 1'b1;
                        if (cnt_q == InitLast) begin
                            cnt_d   = '0;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                StIdle: begin
                    if (tick && !pause) begin
                        cur_dir_d = dir_sel;
                        nxt_d     = next_pos(head_q, dir_sel);
                        grow_d    = (next_pos(head_q, dir_sel) == {apple_c, apple_r});
                        scan_d    = '0;
                        state_d   = StScan;
                    end
                end
                StScan: begin
                    if (hit) begin
                        state_d     = StOver;
                        game_over_d = 1'b1;
                    end else if (scan_q == last_idx) begin
                        state_d = StCommit;
                    end else begin
                        scan_d = scan_q + 7'd1;
                    end
                end
                StCommit: begin
                    tail_d      = ring_tail;
                    ring_push   = 1'b1;
                    head_d      = nxt_q;
                    drop_tail_d = !grow_q || (size_q == MaxSize);
                    if (grow_q) begin
                        eaten_d = 1'b1;
                        if (size_q != MaxSize) begin
                            size_d = size_q + 7'd1;
                        end
                    end
                    state_d = StDraw;
                end
                StDraw: begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = nxt_q;
                    fb_val_d  = 1'b1;
                    state_d   = drop_tail_q ? StClear : StIdle;
                end
                StClear: begin
                    // Chasing the tail: the freshly drawn head pixel must stay lit.
                    if (tail_q != nxt_q) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = tail_q;
                    end
                    state_d = StIdle;
                end
                StOver: ;
                default: state_d = StIdle;
            endcase

            if (tick && !pause && (state_q inside {StScan, StCommit, StDraw, StClear})) begin
                overrun_d = 1'b1;
            end
        end

        busy_d = !(state_d inside {StIdle, StOver});
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            cur_dir_q   <= DirUp;
            cnt_q       <= '0;
            wipe_q      <= 1'b0;
            nxt_q       <= '0;
            grow_q      <= 1'b0;
            drop_tail_q <= 1'b0;
            scan_q      <= '0;
            tail_q      <= '0;
            size_q      <= InitSize;
            head_q      <= InitHead;
            game_over_q <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_val_q    <= 1'b0;
            eaten_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            cnt_q       <= cnt_d;
            wipe_q      <= wipe_d;
            nxt_q       <= nxt_d;
            grow_q      <= grow_d;
            drop_tail_q <= drop_tail_d;
            scan_q      <= scan_d;
            tail_q      <= tail_d;
            size_q      <= size_d;
            head_q      <= head_d;
            game_over_q <= game_over_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_val_q    <= fb_val_d;
            eaten_q     <= eaten_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_val       = fb_val_q;
    assign apple_eaten  = eaten_q;
    assign size         = size_q;
    assign head_c       = head_q[5:3];
    assign head_r       = head_q[2:0];
    assign game_over    = game_over_q;
    assign busy         = busy_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl: expected framebuffer writes and pulses are queued
// by the stimulus thread and consumed by an independent output monitor.
module tb_snake_step_ctrl;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] dir = 3'b000;
    logic       pause = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] apple_c = 3'd5;
    logic [2:0] apple_r = 3'd5;
    logic       fb_we;
    logic [5:0] fb_addr;
    logic       fb_val;
    logic       apple_eaten;
    logic [6:0] size;
    logic [2:0] head_c;
    logic [2:0] head_r;
    logic       game_over;
    logic       busy;
    logic       tick_overrun;

    localparam logic [2:0] UP = 3'b100, RIGHT = 3'b001, LEFT = 3'b110, DOWN = 3'b011;
    localparam int EvWr = 0, EvEat = 1, EvOvr = 2;

    typedef struct {
        int kind;
        int addr;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    snake_step_ctrl dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .tick         (tick),
        .dir          (dir),
        .pause        (pause),
        .restart      (restart),
        .apple_c      (apple_c),
        .apple_r      (apple_r),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_val       (fb_val),
        .apple_eaten  (apple_eaten),
        .size         (size),
        .head_c       (head_c),
        .head_r       (head_r),
        .game_over    (game_over),
        .busy         (busy),
        .tick_overrun (tick_overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input int addr, input int val);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int addr, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d addr=%0d val=%0d want nothing", kind, addr, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.val != val) begin
                bad++;
                $display("FAIL event: got kind=%0d addr=%0d val=%0d want kind=%0d addr=%0d val=%0d",
                         kind, addr, val, e.kind, e.addr, e.val);
            end
        end
    endtask

    // Monitor: kind 0 = fb write, 1 = apple_eaten, 2 = tick_overrun.
    always @(negedge CLK) begin
        if (apple_eaten)  pop_cmp(EvEat, 0, 0);
        if (tick_overrun) pop_cmp(EvOvr, 0, 0);
        if (fb_we)        pop_cmp(EvWr, int'(fb_addr), int'(fb_val));
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (busy && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 want busy=0");
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic do_tick(input logic [2:0] d);
        @(posedge CLK);
        #1 dir = d;
        tick = 1'b1;
        @(posedge CLK);
        #1 tick = 1'b0;
        wait_idle();
    endtask

    task automatic check_pos(input string name, input int c, input int r, input int sz,
                             input int go);
        check_val({name, "_head_c"}, int'(head_c), c);
        check_val({name, "_head_r"}, int'(head_r), r);
        check_val({name, "_size"}, int'(size), sz);
        check_val({name, "_game_over"}, int'(game_over), go);
    endtask

    task automatic move(input string name, input logic [2:0] d, input int draw, input int clr,
                        input int c, input int r, input int sz);
        push_ev(EvWr, draw, 1);
        if (clr >= 0) push_ev(EvWr, clr, 0);
        do_tick(d);
        check_pos(name, c, r, sz, 0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check_pos("reset", 1, 2, 3, 0);
        check_val("reset_fb_we", int'(fb_we), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_eaten", int'(apple_eaten), 0);

        push_ev(EvWr, 10, 1);
        push_ev(EvWr, 9, 1);
        push_ev(EvWr, 8, 1);
        reset_n = 1'b1;
        @(posedge CLK);
        wait_idle();
        check_pos("init", 1, 2, 3, 0);

        move("first_up", UP, 11, 8, 1, 3, 3);

        apple_c = 3'd1;
        apple_r = 3'd4;
        push_ev(EvEat, 0, 0);
        move("grow", UP, 12, -1, 1, 4, 4);
        apple_c = 3'd5;
        apple_r = 3'd5;

        move("up5", UP, 13, 9, 1, 5, 4);
        move("up6", UP, 14, 10, 1, 6, 4);
        move("up7", UP, 15, 11, 1, 7, 4);
        move("wrap", UP, 8, 12, 1, 0, 4);
        move("right", RIGHT, 16, 13, 2, 0, 4);
        move("down_wrap", DOWN, 23, 14, 2, 7, 4);
        move("chase_tail", LEFT, 15, -1, 1, 7, 4);
        move("reverse", RIGHT, 7, 8, 0, 7, 4);

        // Second tick lands while the first move is still scanning.
        push_ev(EvOvr, 0, 0);
        push_ev(EvWr, 0, 1);
        push_ev(EvWr, 16, 0);
        @(posedge CLK);
        #1 dir = UP;
        tick = 1'b1;
        @(posedge CLK);
        #1 tick = 1'b0;
        @(posedge CLK);
        #1 tick = 1'b1;
        @(posedge CLK);
        #1 tick = 1'b0;
        wait_idle();
        check_pos("overrun", 0, 0, 4, 0);

        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1 dir = RIGHT;
            tick = 1'b1;
            @(posedge CLK);
            #1 tick = 1'b0;
            check_val("pause_busy", int'(busy), 0);
        end
        pause = 1'b0;
        repeat (3) @(posedge CLK);
        check_pos("pause", 0, 0, 4, 0);

        apple_c = 3'd1;
        apple_r = 3'd0;
        push_ev(EvEat, 0, 0);
        move("grow5", RIGHT, 8, -1, 1, 0, 5);
        apple_c = 3'd5;
        apple_r = 3'd5;

        do_tick(DOWN);
        check_pos("collide", 1, 0, 5, 1);

        do_tick(UP);
        check_pos("over_tick", 1, 0, 5, 1);

        for (int i = 0; i < 64; i++) push_ev(EvWr, i, 0);
        push_ev(EvWr, 10, 1);
        push_ev(EvWr, 9, 1);
        push_ev(EvWr, 8, 1);
        @(posedge CLK);
        #1 restart = 1'b1;
        @(posedge CLK);
        #1 restart = 1'b0;
        wait_idle();
        check_pos("restart", 1, 2, 3, 0);

        move("after_restart", UP, 11, 8, 1, 3, 3);

        @(posedge CLK);
        #1 dir = UP;
        tick = 1'b1;
        @(posedge CLK);
        #1 tick = 1'b0;
        @(posedge CLK);
        #1 check_val("mid_scan_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_pos("async_reset", 1, 2, 3, 0);
        check_val("async_reset_busy", int'(busy), 0);
        check_val("async_reset_fb_we", int'(fb_we), 0);
        push_ev(EvWr, 10, 1);
        push_ev(EvWr, 9, 1);
        push_ev(EvWr, 8, 1);
        @(posedge CLK);
        #1 reset_n = 1'b1;
        @(posedge CLK);
        wait_idle();
        check_pos("post_reset", 1, 2, 3, 0);

        repeat (4) @(posedge CLK);
        check_val("events_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
